// File: rtl/rf_cnt_sync_slave.sv
// RF edge counter with a WR-cycle-triggered load/snapshot, for aligning a slave RF count to the master.
// Periodic (count, cycle) snapshots are taken on a sampling strobe for the host to read.
module rf_cnt_sync_slave #(
  parameter int unsigned g_cnt_width    = 32,
  parameter int unsigned g_cycles_width = 28,
  parameter int unsigned g_max_edges    = 4
) (
  input  logic                      clk_ref_i,
  input  logic                      rst_n_i,
  input  logic [g_cycles_width-1:0] tm_cycles_i,
  input  logic                      tm_time_valid_i,
  input  logic [2:0]                rf_edges_i,
  input  logic                      cnt_enable_i,
  input  logic [g_cnt_width-1:0]    period_i,
  input  logic [g_cnt_width-1:0]    sync_value_i,
  input  logic [g_cycles_width-1:0] trig_cycles_i,
  input  logic                      arm_i,
  input  logic                      arm_load_i,
  input  logic                      disarm_i,
  input  logic                      sample_p_i,
  output logic [g_cnt_width-1:0]    rf_cnt_o,
  output logic                      armed_o,
  output logic                      done_o,
  output logic [g_cnt_width-1:0]    trig_snap_o,
  output logic [g_cnt_width-1:0]    rf_snap_o,
  output logic [g_cycles_width-1:0] cyc_snap_o,
  output logic                      snap_valid_o
);

  typedef enum logic [1:0] {StIdle, StArmed, StFired} state_e;

  state_e                    r_state;
  logic [g_cycles_width-1:0] r_trig_cycles;
  logic                      r_load_mode;
  logic                      r_armed;
  logic                      r_done;
  logic [g_cnt_width-1:0]    r_trig_snap;
  logic [g_cnt_width-1:0]    r_cnt;
  logic [g_cnt_width-1:0]    r_rf_snap;
  logic [g_cycles_width-1:0] r_cyc_snap;
  logic                      r_snap_valid;

  logic [2:0]                w_edges;
  logic [g_cnt_width:0]      w_sum;
  logic [g_cnt_width:0]      w_period_ext;
  logic [g_cnt_width-1:0]    w_cnt_adv;
  logic [g_cnt_width-1:0]    w_load_val;
  logic                      w_match;
  logic                      w_fire;
  logic                      w_load;

  always_comb begin
    w_edges = (rf_edges_i > 3'(g_max_edges)) ? 3'(g_max_edges) : rf_edges_i;
    // One extra bit so a sum past 2^W still compares correctly against the period.
    w_sum        = {1'b0, r_cnt} + {{(g_cnt_width - 2){1'b0}}, w_edges};
    w_period_ext = {1'b0, period_i};
    if ((period_i != '0) && (w_sum >= w_period_ext)) begin
      w_cnt_adv = g_cnt_width'(w_sum - w_period_ext);
    end else begin
      w_cnt_adv = w_sum[g_cnt_width-1:0];
    end
  end

  always_comb begin
    w_load_val = sync_value_i;
    if ((period_i != '0) && (sync_value_i >= period_i)) begin
      w_load_val = sync_value_i % period_i;
    end
  end

  // Disarm and a fresh arm both take precedence over a match in the same cycle.
  always_comb begin
    w_match = (r_state == StArmed) && tm_time_valid_i && (tm_cycles_i == r_trig_cycles);
    w_fire  = w_match && !disarm_i && !arm_i;
    w_load  = w_fire && r_load_mode;
  end

  always_ff @(posedge clk_ref_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state       <= StIdle;
      r_trig_cycles <= '0;
      r_load_mode   <= 1'b0;
      r_armed       <= 1'b0;
      r_done        <= 1'b0;
      r_trig_snap   <= '0;
    end else begin
      if (disarm_i) begin
        r_state <= StIdle;
        r_armed <= 1'b0;
      end else if (arm_i) begin
        r_state       <= StArmed;
        r_trig_cycles <= trig_cycles_i;
        r_load_mode   <= arm_load_i;
        r_armed       <= 1'b1;
        r_done        <= 1'b0;
      end else if (w_fire) begin
        r_state     <= StFired;
        r_armed     <= 1'b0;
        r_done      <= 1'b1;
        r_trig_snap <= r_cnt;
      end
    end
  end

  // A trigger load discards the edges seen in the load cycle.
  always_ff @(posedge clk_ref_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_cnt <= '0;
    end else if (w_load) begin
      r_cnt <= w_load_val;
    end else if (cnt_enable_i) begin
      r_cnt <= w_cnt_adv;
    end
  end

  always_ff @(posedge clk_ref_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_rf_snap    <= '0;
      r_cyc_snap   <= '0;
      r_snap_valid <= 1'b0;
    end else begin
      r_snap_valid <= sample_p_i;
      if (sample_p_i) begin
        r_rf_snap  <= r_cnt;
        r_cyc_snap <= tm_cycles_i;
      end
    end
  end

  assign rf_cnt_o     = r_cnt;
  assign armed_o      = r_armed;
  assign done_o       = r_done;
  assign trig_snap_o  = r_trig_snap;
  assign rf_snap_o    = r_rf_snap;
  assign cyc_snap_o   = r_cyc_snap;
  assign snap_valid_o = r_snap_valid;

endmodule

// File: tb/tb_rf_cnt_sync_slave.sv
// Scoreboard bench for rf_cnt_sync_slave: a driver runs a behavioural model and queues the expected
// outputs for each clock; a monitor pops and compares them shortly after every rising edge.
module tb_rf_cnt_sync_slave;

  localparam int CW  = 32;
  localparam int YW  = 28;
  localparam int SEC = 1250;

  logic          clk_ref_i;
  logic          rst_n_i;
  logic [YW-1:0] tm_cycles_i;
  logic          tm_time_valid_i;
  logic [2:0]    rf_edges_i;
  logic          cnt_enable_i;
  logic [CW-1:0] period_i;
  logic [CW-1:0] sync_value_i;
  logic [YW-1:0] trig_cycles_i;
  logic          arm_i;
  logic          arm_load_i;
  logic          disarm_i;
  logic          sample_p_i;
  logic [CW-1:0] rf_cnt_o;
  logic          armed_o;
  logic          done_o;
  logic [CW-1:0] trig_snap_o;
  logic [CW-1:0] rf_snap_o;
  logic [YW-1:0] cyc_snap_o;
  logic          snap_valid_o;

  rf_cnt_sync_slave #(
    .g_cnt_width   (CW),
    .g_cycles_width(YW),
    .g_max_edges   (4)
  ) u_dut (
    .clk_ref_i      (clk_ref_i),
    .rst_n_i        (rst_n_i),
    .tm_cycles_i    (tm_cycles_i),
    .tm_time_valid_i(tm_time_valid_i),
    .rf_edges_i     (rf_edges_i),
    .cnt_enable_i   (cnt_enable_i),
    .period_i       (period_i),
    .sync_value_i   (sync_value_i),
    .trig_cycles_i  (trig_cycles_i),
    .arm_i          (arm_i),
    .arm_load_i     (arm_load_i),
    .disarm_i       (disarm_i),
    .sample_p_i     (sample_p_i),
    .rf_cnt_o       (rf_cnt_o),
    .armed_o        (armed_o),
    .done_o         (done_o),
    .trig_snap_o    (trig_snap_o),
    .rf_snap_o      (rf_snap_o),
    .cyc_snap_o     (cyc_snap_o),
    .snap_valid_o   (snap_valid_o)
  );

  initial clk_ref_i = 1'b0;
  always #5 clk_ref_i = ~clk_ref_i;

  typedef struct packed {
    logic [CW-1:0] cnt;
    logic          armed;
    logic          done;
    logic [CW-1:0] trig_snap;
    logic [CW-1:0] rf_snap;
    logic [YW-1:0] cyc_snap;
    logic          sv;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Staged stimulus, applied at the next falling edge.
  logic          s_rst_n   = 1'b0;
  int            s_edges   = 3;
  logic          s_en      = 1'b1;
  logic [CW-1:0] s_period  = 100;
  logic [CW-1:0] s_sync    = 0;
  int            s_trig    = 0;
  logic          s_arm     = 1'b0;
  logic          s_load    = 1'b0;
  logic          s_disarm  = 1'b0;
  logic          s_sample  = 1'b0;
  logic          s_valid   = 1'b1;
  int            tm        = 0;

  // Reference model state
  longint unsigned m_cnt, m_trig_snap, m_rf_snap;
  int              m_cyc_snap, m_trig;
  bit              m_armed, m_done, m_load, m_sv;

  task automatic model_reset();
    m_cnt = 0; m_trig_snap = 0; m_rf_snap = 0; m_cyc_snap = 0;
    m_trig = 0; m_armed = 0; m_done = 0; m_load = 0; m_sv = 0;
  endtask

  task automatic model_step();
    longint unsigned n;
    int  e;
    bit  fire;
    if (!s_rst_n) begin
      model_reset();
      return;
    end
    e    = (s_edges > 4) ? 4 : s_edges;
    fire = 0;
    m_sv = s_sample;
    if (s_sample) begin
      m_rf_snap  = m_cnt;
      m_cyc_snap = tm;
    end
    if (s_disarm) begin
      m_armed = 0;
    end else if (s_arm) begin
      m_armed = 1; m_done = 0; m_trig = s_trig; m_load = s_load;
    end else if (m_armed && s_valid && tm == m_trig) begin
      m_armed = 0; m_done = 1; m_trig_snap = m_cnt; fire = 1;
    end
    if (fire && m_load) begin
      m_cnt = (s_period != 0) ? longint'(s_sync) % longint'(s_period) : longint'(s_sync);
    end else if (s_en) begin
      n = m_cnt + longint'(e);
      if (s_period != 0 && n >= longint'(s_period)) n = n - longint'(s_period);
      m_cnt = n & 64'hFFFF_FFFF;
    end
  endtask

  task automatic tick();
    exp_t x;
    @(negedge clk_ref_i);
    rst_n_i         = s_rst_n;
    tm_cycles_i     = YW'(tm);
    tm_time_valid_i = s_valid;
    rf_edges_i      = 3'(s_edges);
    cnt_enable_i    = s_en;
    period_i        = s_period;
    sync_value_i    = s_sync;
    trig_cycles_i   = YW'(s_trig);
    arm_i           = s_arm;
    arm_load_i      = s_load;
    disarm_i        = s_disarm;
    sample_p_i      = s_sample;
    model_step();
    x.cnt       = m_cnt[CW-1:0];
    x.armed     = m_armed;
    x.done      = m_done;
    x.trig_snap = m_trig_snap[CW-1:0];
    x.rf_snap   = m_rf_snap[CW-1:0];
    x.cyc_snap  = YW'(m_cyc_snap);
    x.sv        = m_sv;
    q.push_back(x);
    tm       = (tm + 1) % SEC;
    s_arm    = 1'b0;
    s_disarm = 1'b0;
    s_sample = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic run_to(input int target);
    for (int i = 0; i < SEC && tm != target; i++) tick();
  endtask

  task automatic arm(input int trig, input logic load, input logic [CW-1:0] sync);
    s_arm = 1'b1; s_trig = trig; s_load = load; s_sync = sync;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk_ref_i);
      #2;
      if (q.size() > 0) begin
        x = q.pop_front();
        chk("rf_cnt",     64'(rf_cnt_o),     64'(x.cnt));
        chk("armed",      64'(armed_o),      64'(x.armed));
        chk("done",       64'(done_o),       64'(x.done));
        chk("trig_snap",  64'(trig_snap_o),  64'(x.trig_snap));
        chk("rf_snap",    64'(rf_snap_o),    64'(x.rf_snap));
        chk("cyc_snap",   64'(cyc_snap_o),   64'(x.cyc_snap));
        chk("snap_valid", 64'(snap_valid_o), 64'(x.sv));
      end
    end
  end

  initial begin : driver
    int p;
    model_reset();
    run(3);
    s_rst_n = 1'b1;

    // Wrap at period 100 with 3 edges per cycle
    run(40);

    // Load-mode trigger at cycle 1000
    run_to(900);
    arm(1000, 1'b1, 123);
    run(150);

    // Snapshot-only trigger at cycle 500
    run_to(400);
    arm(500, 1'b0, 0);
    run(150);

    // Time invalid at the match: fires one second later
    run_to(650);
    arm(700, 1'b1, 5);
    run_to(700);
    s_valid = 1'b0;
    tick();
    s_valid = 1'b1;
    run(SEC + 10);

    // Arm and disarm together, then disarm before the match
    arm((tm + 5) % SEC, 1'b1, 77);
    s_disarm = 1'b1;
    run(20);
    arm((tm + 10) % SEC, 1'b1, 77);
    run(3);
    s_disarm = 1'b1;
    run(20);

    // Arm in the very cycle of the match waits a full second
    arm(tm, 1'b1, 42);
    run(SEC + 5);

    // Sample coincident with load: snapshot sees 57, counter becomes 10
    s_en = 1'b0;
    arm((tm + 3) % SEC, 1'b1, 57);
    run(6);
    p = (tm + 3) % SEC;
    arm(p, 1'b1, 10);
    tick();
    run_to(p);
    s_sample = 1'b1;
    run(3);
    s_en = 1'b1;

    // Sync value above period loads modulo period
    arm((tm + 4) % SEC, 1'b1, 345);
    run(10);

    // Free-running wrap at 2^32
    s_period = 0;
    arm((tm + 2) % SEC, 1'b1, 32'hFFFF_FFF0);
    run(15);

    // Reset while armed
    arm((tm + 200) % SEC, 1'b1, 9);
    run(5);
    s_rst_n = 1'b0;
    run(2);
    s_rst_n = 1'b1;
    run(5);

    // Randomised traffic
    for (int ph = 0; ph < 8; ph++) begin
      case (ph % 4)
        0:       s_period = 0;
        1:       s_period = 100;
        2:       s_period = 1000;
        default: s_period = $urandom_range(1, 5000);
      endcase
      for (int i = 0; i < 500; i++) begin
        s_edges  = $urandom_range(0, 7);
        s_en     = ($urandom_range(0, 9) != 0);
        s_valid  = ($urandom_range(0, 19) != 0);
        s_sample = ($urandom_range(0, 9) == 0);
        if ($urandom_range(0, 59) == 0) begin
          arm((tm + $urandom_range(0, 80)) % SEC, 1'($urandom_range(0, 1)),
              ($urandom_range(0, 1) != 0) ? CW'($urandom) : CW'($urandom_range(0, 3 * 5000)));
        end
        if ($urandom_range(0, 199) == 0) s_disarm = 1'b1;
        if ($urandom_range(0, 999) == 0) s_rst_n = 1'b0;
        tick();
        s_rst_n = 1'b1;
      end
    end
    s_valid = 1'b1;
    run(2);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk_ref_i);
    #3;
    chk("queue_drain", 64'(q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
